// File: rtl/dcache_2way_top.sv
// dcache_2way_top: 2-way set-associative write-back data cache with per-set LRU and saturating access/miss counters
// Ports: clk_i/rst_i (async active-low); mem_* refill/write-back port (line-wide, ack-pulsed);
// p1_* CPU load/store port (stalled on miss); access_cnt_o/miss_cnt_o statistics.
module dcache_2way_top #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [31:0]       p1_data_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  output logic [31:0]       access_cnt_o,
  output logic [31:0]       miss_cnt_o
);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int WORDS = LINE_W / 32;
  typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE} state_t;
  state_t state_q, state_d;
  logic [SETS-1:0][1:0] valid_q, dirty_q;
  logic [SETS-1:0] lru_q;
  logic [TAG_W-1:0] tag_q [SETS][2];
  logic [WORDS-1:0][31:0] data_q [SETS][2];
  logic victim_q, vic, hit0, hit1, hit_w, hit, req;
  logic [31:0] access_cnt_q, miss_cnt_q;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [OFF_W-3:0] word;
  logic unused_lsb;
  assign unused_lsb = ^p1_addr_i[1:0];
  assign idx = p1_addr_i[OFF_W+IDX_W-1:OFF_W];
  assign tag = p1_addr_i[ADDR_W-1:OFF_W+IDX_W];
  assign word = p1_addr_i[OFF_W-1:2];
  assign req = p1_MemRead_i | p1_MemWrite_i;
  assign hit0 = valid_q[idx][0] && tag_q[idx][0] == tag;
  assign hit1 = valid_q[idx][1] && tag_q[idx][1] == tag;
  assign hit_w = hit1;
  assign hit = state_q == IDLE && (hit0 || hit1);
  assign p1_stall_o = req & ~hit;
  assign p1_data_o = hit ? data_q[idx][hit_w][word] : '0;
  // Prefer filling an empty way before evicting the least-recently-used one
  assign vic = !valid_q[idx][0] ? 1'b0 : !valid_q[idx][1] ? 1'b1 : lru_q[idx];
  assign access_cnt_o = access_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
  always_comb begin
    state_d = state_q;
    mem_enable_o = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    case (state_q)
      IDLE: state_d = (req && !hit) ? MISS : IDLE;
      MISS: state_d = (valid_q[idx][vic] && dirty_q[idx][vic]) ? WRITEBACK : REFILL;
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o = 1'b1;
        mem_addr_o = {tag_q[idx][victim_q], idx, {OFF_W{1'b0}}};
        mem_data_o = data_q[idx][victim_q];
        state_d = mem_ack_i ? REFILL : WRITEBACK;
      end
      REFILL: begin
        mem_enable_o = 1'b1;
        mem_addr_o = {tag, idx, {OFF_W{1'b0}}};
        state_d = mem_ack_i ? REFILL_DONE : REFILL;
      end
      REFILL_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      lru_q <= '0;
      victim_q <= 1'b0;
      access_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == MISS) victim_q <= vic;
      if (req && hit) begin
        lru_q[idx] <= ~hit_w;
        if (access_cnt_q != '1) access_cnt_q <= access_cnt_q + 32'd1;
        if (p1_MemWrite_i) dirty_q[idx][hit_w] <= 1'b1;
      end
      if (state_q == IDLE && req && !hit && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
      if (state_q == REFILL && mem_ack_i) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
      end
    end
  end
  // Tag and data arrays carry no reset; valid bits gate every use of them
  always_ff @(posedge clk_i) begin
    if (req && hit && p1_MemWrite_i) data_q[idx][hit_w][word] <= p1_data_i;
    if (state_q == REFILL && mem_ack_i) begin
      data_q[idx][victim_q] <= mem_data_i;
      tag_q[idx][victim_q] <= tag;
    end
  end
endmodule

// File: tb/tb_dcache_2way_top.sv
// tb_dcache_2way_top: scoreboard bench for dcache_2way_top with a latency-programmable memory responder
module tb_dcache_2way_top;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic [255:0] mem_data_i, mem_data_o;
  logic mem_ack_i, mem_enable_o, mem_write_o;
  logic [31:0] mem_addr_o, p1_data_i, p1_addr_i, p1_data_o, access_cnt_o, miss_cnt_o;
  logic p1_MemRead_i, p1_MemWrite_i, p1_stall_o;
  typedef struct {logic wr; logic [31:0] addr; logic [255:0] data;} txn_t;
  txn_t mem_sb[$];
  logic [31:0] rd_sb[$];
  logic [255:0] mem_store [logic [31:0]];
  int n_chk = 0, n_pass = 0, mem_lat = 2, busy = 0;
  txn_t t;

  dcache_2way_top dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i), .mem_data_o(mem_data_o),
    .mem_addr_o(mem_addr_o), .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .p1_data_i(p1_data_i), .p1_addr_i(p1_addr_i), .p1_MemRead_i(p1_MemRead_i),
    .p1_MemWrite_i(p1_MemWrite_i), .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
    .access_cnt_o(access_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    if (mem_store.exists(a)) return mem_store[a];
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'hC0DE_0000 ^ a ^ 32'(i);
    return l;
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [255:0] l;
    l = line_of({a[31:5], 5'd0});
    return l[a[4:2]*32 +: 32];
  endfunction

  task automatic exp_txn(input logic wr, input logic [31:0] a, input logic [255:0] d);
    txn_t e;
    e.wr = wr;
    e.addr = a;
    e.data = d;
    mem_sb.push_back(e);
  endtask

  // Memory responder: checks each new transfer against the scoreboard, acks after mem_lat cycles
  initial begin
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (rst_i && mem_enable_o) begin
        if (busy == 0) begin
          n_chk++;
          if (mem_sb.size() == 0) $display("FAIL mem_txn unexpected wr=%b addr=%h", mem_write_o, mem_addr_o);
          else begin
            t = mem_sb.pop_front();
            if (mem_write_o !== t.wr || mem_addr_o !== t.addr || (t.wr && mem_data_o !== t.data))
              $display("FAIL mem_txn got wr=%b addr=%h data=%h want wr=%b addr=%h data=%h",
                       mem_write_o, mem_addr_o, mem_data_o, t.wr, t.addr, t.data);
            else n_pass++;
          end
        end
        busy++;
        if (busy >= mem_lat) begin
          busy = 0;
          mem_ack_i = 1'b1;
          if (mem_write_o) mem_store[mem_addr_o] = mem_data_o;
          else mem_data_i = line_of(mem_addr_o);
        end
      end else busy = 0;
    end
  end

  task automatic access(input bit wr, input bit both, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input int exp_st, input string nm);
    int st;
    logic [31:0] e;
    if (!wr) rd_sb.push_back(exp_rd);
    p1_MemRead_i = !wr || both;
    p1_MemWrite_i = wr;
    p1_addr_i = a;
    p1_data_i = wd;
    st = 0;
    #1;
    while (p1_stall_o && st < 300) begin
      @(negedge clk_i);
      #1;
      st++;
    end
    n_chk++;
    if (st != exp_st) $display("FAIL %s_stall got %0d want %0d", nm, st, exp_st);
    else n_pass++;
    if (!wr) begin
      e = rd_sb.pop_front();
      n_chk++;
      if (p1_data_o !== e) $display("FAIL %s_data got %h want %h", nm, p1_data_o, e);
      else n_pass++;
    end
    @(negedge clk_i);
    p1_MemRead_i = 1'b0;
    p1_MemWrite_i = 1'b0;
  endtask

  task automatic do_reset;
    p1_MemRead_i = 1'b0;
    p1_MemWrite_i = 1'b0;
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_reset;
    p1_MemRead_i = 1'b0;
    p1_MemWrite_i = 1'b0;
    p1_addr_i = '0;
    p1_data_i = '0;
    rst_i = 1'b0;
    #2;
    n_chk++; if (mem_enable_o !== 1'b0) $display("FAIL rst_enable got %b want 0", mem_enable_o); else n_pass++;
    n_chk++; if (mem_write_o !== 1'b0) $display("FAIL rst_write got %b want 0", mem_write_o); else n_pass++;
    n_chk++; if (mem_addr_o !== 32'd0) $display("FAIL rst_addr got %h want 0", mem_addr_o); else n_pass++;
    n_chk++; if (mem_data_o !== 256'd0) $display("FAIL rst_mdata got %h want 0", mem_data_o); else n_pass++;
    n_chk++; if (access_cnt_o !== 32'd0) $display("FAIL rst_access got %h want 0", access_cnt_o); else n_pass++;
    n_chk++; if (miss_cnt_o !== 32'd0) $display("FAIL rst_miss got %h want 0", miss_cnt_o); else n_pass++;
    n_chk++; if (p1_stall_o !== 1'b0) $display("FAIL rst_stall got %b want 0", p1_stall_o); else n_pass++;
    n_chk++; if (p1_data_o !== 32'd0) $display("FAIL rst_pdata got %h want 0", p1_data_o); else n_pass++;
    do_reset();
  endtask

  task automatic test_cold_load;
    mem_lat = 2;
    exp_txn(1'b0, 32'h40, '0);
    access(1'b0, 1'b0, 32'h40, '0, 32'hC0DE_0040, 5, "cold");
    n_chk++; if (miss_cnt_o !== 32'd1) $display("FAIL cold_miss_cnt got %h want 1", miss_cnt_o); else n_pass++;
    n_chk++; if (access_cnt_o !== 32'd1) $display("FAIL cold_access_cnt got %h want 1", access_cnt_o); else n_pass++;
  endtask

  task automatic test_store_hit;
    access(1'b1, 1'b0, 32'h44, 32'hDEADBEEF, '0, 0, "st_hit");
    access(1'b0, 1'b0, 32'h44, '0, 32'hDEADBEEF, 0, "ld_hit");
    access(1'b1, 1'b1, 32'h48, 32'h1234_5678, '0, 0, "st_both");
    access(1'b0, 1'b0, 32'h48, '0, 32'h1234_5678, 0, "ld_both");
    n_chk++; if (access_cnt_o !== 32'd5) $display("FAIL hit_access_cnt got %h want 5", access_cnt_o); else n_pass++;
    n_chk++; if (miss_cnt_o !== 32'd1) $display("FAIL hit_miss_cnt got %h want 1", miss_cnt_o); else n_pass++;
  endtask

  task automatic test_lru_clean;
    do_reset();
    mem_lat = 2;
    exp_txn(1'b0, 32'h40, '0);
    access(1'b0, 1'b0, 32'h40, '0, word_of(32'h40), 5, "lru_a");
    exp_txn(1'b0, 32'h240, '0);
    access(1'b0, 1'b0, 32'h240, '0, word_of(32'h240), 5, "lru_b");
    access(1'b0, 1'b0, 32'h40, '0, word_of(32'h40), 0, "lru_a2");
    exp_txn(1'b0, 32'h440, '0);
    access(1'b0, 1'b0, 32'h440, '0, word_of(32'h440), 5, "lru_c");
    access(1'b0, 1'b0, 32'h40, '0, word_of(32'h40), 0, "lru_a_kept");
    exp_txn(1'b0, 32'h240, '0);
    access(1'b0, 1'b0, 32'h240, '0, word_of(32'h240), 5, "lru_b_gone");
  endtask

  task automatic test_dirty_evict;
    logic [255:0] l;
    do_reset();
    mem_lat = 2;
    exp_txn(1'b0, 32'h40, '0);
    access(1'b1, 1'b0, 32'h44, 32'hDEADBEEF, '0, 5, "wmiss");
    exp_txn(1'b0, 32'h240, '0);
    access(1'b0, 1'b0, 32'h244, '0, word_of(32'h244), 5, "de_fill");
    access(1'b0, 1'b0, 32'h244, '0, word_of(32'h244), 0, "de_touch");
    l = line_of(32'h40);
    l[63:32] = 32'hDEADBEEF;
    exp_txn(1'b1, 32'h40, l);
    exp_txn(1'b0, 32'h440, '0);
    access(1'b0, 1'b0, 32'h444, '0, word_of(32'h444), 7, "de_evict");
    exp_txn(1'b0, 32'h40, '0);
    access(1'b0, 1'b0, 32'h44, '0, 32'hDEADBEEF, 5, "de_reload");
    n_chk++; if (miss_cnt_o !== 32'd4) $display("FAIL de_miss_cnt got %h want 4", miss_cnt_o); else n_pass++;
    n_chk++; if (access_cnt_o !== 32'd5) $display("FAIL de_access_cnt got %h want 5", access_cnt_o); else n_pass++;
  endtask

  task automatic test_reset_abort;
    logic [255:0] l;
    int n;
    do_reset();
    mem_lat = 2;
    exp_txn(1'b0, 32'h40, '0);
    access(1'b1, 1'b0, 32'h44, 32'hCAFEF00D, '0, 5, "ab_st");
    exp_txn(1'b0, 32'h240, '0);
    access(1'b0, 1'b0, 32'h244, '0, word_of(32'h244), 5, "ab_fill");
    access(1'b0, 1'b0, 32'h244, '0, word_of(32'h244), 0, "ab_touch");
    mem_lat = 20;
    l = line_of(32'h40);
    l[63:32] = 32'hCAFEF00D;
    exp_txn(1'b1, 32'h40, l);
    p1_addr_i = 32'h444;
    p1_MemRead_i = 1'b1;
    n = 0;
    while (!(mem_enable_o && mem_write_o) && n < 20) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    n_chk++; if (n >= 20) $display("FAIL ab_wb_start got timeout want writeback"); else n_pass++;
    @(negedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    n_chk++; if (mem_enable_o !== 1'b0) $display("FAIL ab_enable got %b want 0", mem_enable_o); else n_pass++;
    n_chk++; if (mem_write_o !== 1'b0) $display("FAIL ab_write got %b want 0", mem_write_o); else n_pass++;
    n_chk++; if (mem_addr_o !== 32'd0) $display("FAIL ab_addr got %h want 0", mem_addr_o); else n_pass++;
    p1_MemRead_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    n_chk++; if (miss_cnt_o !== 32'd0) $display("FAIL ab_miss_cnt got %h want 0", miss_cnt_o); else n_pass++;
    n_chk++; if (access_cnt_o !== 32'd0) $display("FAIL ab_access_cnt got %h want 0", access_cnt_o); else n_pass++;
    mem_lat = 2;
    exp_txn(1'b0, 32'h40, '0);
    access(1'b0, 1'b0, 32'h44, '0, word_of(32'h44), 5, "ab_reload");
    n_chk++; if (miss_cnt_o !== 32'd1) $display("FAIL ab_miss_after got %h want 1", miss_cnt_o); else n_pass++;
  endtask

  task automatic test_saturation;
    do_reset();
    mem_lat = 1;
    force dut.miss_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.miss_cnt_q;
    #1;
    n_chk++; if (miss_cnt_o !== 32'hFFFF_FFFE) $display("FAIL sat_preload got %h want fffffffe", miss_cnt_o); else n_pass++;
    exp_txn(1'b0, 32'h80, '0);
    access(1'b0, 1'b0, 32'h80, '0, word_of(32'h80), 4, "sat_m1");
    n_chk++; if (miss_cnt_o !== 32'hFFFF_FFFF) $display("FAIL sat_m1_cnt got %h want ffffffff", miss_cnt_o); else n_pass++;
    exp_txn(1'b0, 32'hA0, '0);
    access(1'b0, 1'b0, 32'hA4, '0, word_of(32'hA4), 4, "sat_m2");
    n_chk++; if (miss_cnt_o !== 32'hFFFF_FFFF) $display("FAIL sat_m2_cnt got %h want ffffffff", miss_cnt_o); else n_pass++;
    n_chk++; if (access_cnt_o !== 32'd2) $display("FAIL sat_access got %h want 2", access_cnt_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_store_hit();
    test_lru_clean();
    test_dirty_evict();
    test_reset_abort();
    test_saturation();
    repeat (2) @(negedge clk_i);
    n_chk++; if (mem_sb.size() != 0) $display("FAIL mem_txn_left got %0d want 0", mem_sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dcache_2way_top.md
DCACHE_2WAY_TOP -- requirements
Module: dcache_2way_top

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: byte address width.
REQ-002 SHALL have parameter LINE_W, default 256: line width in bits; a power of two, minimum 64.
REQ-003 SHALL have parameter SETS, default 16: number of sets; a power of two, minimum 2.
REQ-004 SHALL derive OFF_W=log2(LINE_W/8), IDX_W=log2(SETS) and TAG_W=ADDR_W-IDX_W-OFF_W; the way count is fixed at 2.
REQ-005 clk_i  in  1  clock; all state updates on the rising edge.
REQ-006 rst_i  in  1  reset, asynchronous, active-low.
REQ-007 mem_data_i  in  LINE_W  refill line from memory.
REQ-008 mem_ack_i  in  1  memory transfer complete, one-cycle pulse.
REQ-009 mem_data_o  out  LINE_W  write-back line.
REQ-010 mem_addr_o  out  ADDR_W  line-aligned memory address.
REQ-011 mem_enable_o  out  1  memory request.
REQ-012 mem_write_o  out  1  1 = write-back, 0 = refill.
REQ-013 p1_data_i  in  32  CPU store data.
REQ-014 p1_addr_i  in  ADDR_W  CPU byte address; bits [1:0] are ignored.
REQ-015 p1_MemRead_i  in  1  load request.
REQ-016 p1_MemWrite_i  in  1  store request; if both strobes are high, the request is treated as a store.
REQ-017 p1_data_o  out  32  load data.
REQ-018 p1_stall_o  out  1  CPU must hold the request.
REQ-019 access_cnt_o  out  32  completed accesses, saturating.
REQ-020 miss_cnt_o  out  32  misses, saturating.

Function
REQ-021 SHALL store, per set and per way, the fields valid, dirty, tag[TAG_W] and data[LINE_W], plus one LRU bit per set; storage is internal registers.
REQ-022 SHALL decompose the address as offset=addr[OFF_W-1:0], index=addr[OFF_W+IDX_W-1:OFF_W] and tag=addr[ADDR_W-1:OFF_W+IDX_W].
REQ-023 SHALL define hit combinationally as: state==IDLE, and some way is valid with a matching tag; at most one way may match.
REQ-024 SHALL drive p1_stall_o = (p1_MemRead_i|p1_MemWrite_i) & ~hit, combinationally.
REQ-025 On a hit, p1_data_o SHALL equal 32-bit word addr[OFF_W-1:2] of the hit line in the same cycle; otherwise p1_data_o SHALL be 0.
REQ-026 On a store hit, at the clock edge, SHALL write p1_data_i into that word and set dirty=1 on the hit way.
REQ-027 On any hit, SHALL set the set's LRU bit to point at the other way.
REQ-028 On any hit, SHALL increment access_cnt_o by 1.
REQ-029 SHALL implement the FSM states IDLE, MISS, WRITEBACK, REFILL and REFILL_DONE.
REQ-030 IDLE -> MISS when a request is present and there is no hit; miss_cnt_o increments at that edge.
REQ-031 In MISS, SHALL select the victim in this order: invalid way 0, then invalid way 1, then the LRU way; the victim is latched for the remainder of the miss.
REQ-032 From MISS, SHALL go to WRITEBACK if the victim is valid and dirty, otherwise to REFILL.
REQ-033 In WRITEBACK, SHALL drive mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, OFF_W'b0} and mem_data_o=victim line, held stable until mem_ack_i; then go to REFILL.
REQ-034 In REFILL, SHALL drive mem_enable_o=1, mem_write_o=0 and mem_addr_o={req tag, index, 0}; on mem_ack_i, SHALL load the victim way with mem_data_i, set valid=1, dirty=0 and tag=req tag, then go to REFILL_DONE.
REQ-035 REFILL_DONE SHALL last one cycle with mem_enable_o=0, then go to IDLE, where the retried access hits.
REQ-036 A write miss SHALL allocate the line and then complete as a store hit.
REQ-037 In all other states, mem_enable_o=0, mem_write_o=0, mem_addr_o=0 and mem_data_o=0.
REQ-038 mem_ack_i SHALL be ignored in IDLE, MISS and REFILL_DONE.
REQ-039 The CPU contract: address, strobes and data are held stable while p1_stall_o=1; the behaviour is undefined if this is violated.
REQ-040 Both counters SHALL saturate at 32'hFFFF_FFFF with no wrap.
REQ-041 Hit latency SHALL be 0 cycles; a clean miss SHALL stall for 3 + memory latency cycles; a dirty miss SHALL additionally stall for the write-back duration.

Reset
REQ-042 While rst_i=0, SHALL asynchronously set state=IDLE and clear all valid, dirty and LRU bits and both counters.
REQ-043 While rst_i=0, all memory outputs SHALL be 0; data and tag arrays need not be reset.
REQ-044 A reset asserted mid-WRITEBACK or mid-REFILL SHALL abort the transfer, dropping mem_enable_o immediately; the line is not installed.

Verification
REQ-045 Cold load 0x0000_0040 with 2-cycle ack -> stall; REFILL at addr 0x40; then a hit returns word 0 of the fill; miss_cnt=1, access_cnt=1.
REQ-046 Store 0xDEADBEEF to 0x44 after the above, then load 0x44 -> both hit with zero stall; load returns 0xDEADBEEF; way dirty.
REQ-047 Touch 0x40, 0x240, 0x40, then 0x440 (same set 2, defaults) -> victim is the way holding 0x240; if that way is clean, no WRITEBACK occurs.
REQ-048 Dirty 0x44, fill 0x244, access 0x244, then load 0x444 -> WRITEBACK at 0x40 carrying 0xDEADBEEF in word 1, then REFILL at 0x440.
REQ-049 Drop rst_i during WRITEBACK -> mem_enable_o=0 that cycle; after release, a load of 0x44 misses; counters read 0.
REQ-050 Preload miss_cnt to 0xFFFF_FFFE via forced misses or force; two further misses -> counter holds 0xFFFF_FFFF.
